// File: rtl/uart_bus_sched.sv
// Register-port master for one uart: programs divider/control after reset, then
// round-robin shares the port between two byte senders and one RX reader.
module uart_bus_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] div_in,
   input  logic [7:0]  cr_in,
   input  logic        reinit,
   output logic        init_done,
   input  logic        tx0_valid,
   input  logic [7:0]  tx0_data,
   output logic        tx0_ready,
   input  logic        tx1_valid,
   input  logic [7:0]  tx1_data,
   output logic        tx1_ready,
   input  logic        rx_req,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic [4:0]  addr,
   output logic        re,
   output logic        we,
   output logic [31:0] wd,
   input  logic [31:0] rd
);

   localparam logic [4:0] ADDR_CR    = 5'h00;
   localparam logic [4:0] ADDR_TX_RX = 5'h04;
   localparam logic [4:0] ADDR_DR    = 5'h08;

   typedef enum logic [2:0] {S_DIV, S_CR, S_IDLE, S_POLL, S_WR, S_RX} state_t;

   state_t      state, state_nxt;
   logic [1:0]  last, last_nxt;
   logic [7:0]  hold, hold_nxt;
   logic [3:0]  req;
   logic [1:0]  c1, c2, c3, win;
   logic        win_vld;
   logic        unused_rd;

   assign unused_rd = ^rd[31:8];

   function automatic logic [1:0] rr_next(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Search order begins one past the last winner so nobody starves.
   assign req = {1'b0, rx_req, tx1_valid, tx0_valid};
   assign c1  = rr_next(last);
   assign c2  = rr_next(c1);
   assign c3  = rr_next(c2);

   always_comb begin
      win     = 2'd0;
      win_vld = 1'b0;
      if (req[c1]) begin
         win     = c1;
         win_vld = 1'b1;
      end else if (req[c2]) begin
         win     = c2;
         win_vld = 1'b1;
      end else if (req[c3]) begin
         win     = c3;
         win_vld = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      hold_nxt  = hold;
      addr      = 5'h00;
      re        = 1'b0;
      we        = 1'b0;
      wd        = 32'h0;
      init_done = 1'b0;
      tx0_ready = 1'b0;
      tx1_ready = 1'b0;
      case (state)
         S_DIV: begin
            we        = 1'b1;
            addr      = ADDR_DR;
            wd        = {16'h0, div_in};
            state_nxt = S_CR;
         end
         S_CR: begin
            we        = 1'b1;
            addr      = ADDR_CR;
            wd        = {24'h0, cr_in};
            state_nxt = S_IDLE;
         end
         S_IDLE: begin
            init_done = 1'b1;
            if (reinit) begin
               state_nxt = S_DIV;
            end else if (win_vld) begin
               last_nxt = win;
               if (win == 2'd0) hold_nxt = tx0_data;
               else if (win == 2'd1) hold_nxt = tx1_data;
               state_nxt = (win == 2'd2) ? S_RX : S_POLL;
            end
         end
         S_POLL: begin
            re        = 1'b1;
            addr      = ADDR_CR;
            state_nxt = rd[2] ? S_IDLE : S_WR;
         end
         S_WR: begin
            we        = 1'b1;
            addr      = ADDR_TX_RX;
            wd        = {24'h0, hold};
            tx0_ready = (last == 2'd0);
            tx1_ready = (last == 2'd1);
            state_nxt = S_IDLE;
         end
         S_RX: begin
            re        = 1'b1;
            addr      = ADDR_TX_RX;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_DIV;
      endcase
      // Reset state is S_DIV, so strobes must be forced quiet while rst is held.
      if (rst) begin
         addr      = 5'h00;
         re        = 1'b0;
         we        = 1'b0;
         wd        = 32'h0;
         init_done = 1'b0;
         tx0_ready = 1'b0;
         tx1_ready = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_DIV;
         last     <= 2'd2;
         hold     <= 8'h00;
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         hold     <= hold_nxt;
         rx_valid <= (state == S_RX);
         if (state == S_RX) rx_data <= rd[7:0];
      end
   end

endmodule

// File: doc/uart_bus_sched.md
# uart_bus_sched

Master-side controller for the `uart` simple register interface. After reset, it writes the divider and control registers. It then shares the single register port between two byte transmitters and one receive-read requester using round-robin arbitration. Before every TX write it polls the control register and never pushes into a full TX FIFO. It sits between client logic and one `uart` instance; the `uart` `addr/re/we/wd/rd` pins connect directly to this block.

## Interface
- `ADDR_CR`, 5'h00, address of the UART control register
- `ADDR_TX_RX`, 5'h04, address of the TX write / RX read data register
- `ADDR_DR`, 5'h08, address of the baud divider register
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `div_in`  in  16  divider value written at init
- `cr_in`  in  8  control value written at init (`wd[0]` tr_en, `wd[1]` rec_en, `wd[5:4]` tx lvl, `wd[7:6]` rx lvl)
- `reinit`  in  1  request to rerun the init sequence
- `init_done`  out  1  high while configured and servicing requests
- `tx0_valid`, `tx1_valid`  in  1 each  byte-send request
- `tx0_data`, `tx1_data`  in  8 each  byte to send
- `tx0_ready`, `tx1_ready`  out  1 each  one-cycle pulse when the byte is written to the UART
- `rx_req`  in  1  request to pop one received byte
- `rx_data`  out  8  popped byte; holds its value until the next pop
- `rx_valid`  out  1  one-cycle pulse when `rx_data` is updated
- `addr`  out  5  UART address
- `re`  out  1  UART read enable
- `we`  out  1  UART write enable
- `wd`  out  32  UART write data
- `rd`  in  32  UART read data (combinational from `addr`)

## Operation
- FSM states: `S_DIV`, `S_CR`, `S_IDLE`, `S_POLL`, `S_WR`, `S_RX`. Reset state is `S_DIV`.
- `S_DIV`: `we`=1, `addr`=`ADDR_DR`, `wd`={16'h0,`div_in`}. Next state `S_CR`.
- `S_CR`: `we`=1, `addr`=`ADDR_CR`, `wd`={24'h0,`cr_in`}. Next state `S_IDLE`.
- `S_IDLE`: `init_done`=1 and all bus strobes are 0.
  - If `reinit`=1, go to `S_DIV`. This has priority over all requests.
  - Otherwise, if any request is pending, grant it.
- Arbitration:
  - Requester indices: 0 = tx0, 1 = tx1, 2 = rx.
  - 2-bit last-grant pointer, reset value 2, so tx0 has first priority after reset.
  - Search order starts at (last+1) mod 3. The first pending requester wins.
  - On grant, the pointer is set to the winner and the winner's tx data is latched into an 8-bit holding register.
  - A tx grant goes to `S_POLL`; an rx grant goes to `S_RX`.
- `S_POLL`: `re`=1, `addr`=`ADDR_CR`.
  - `rd[2]` (tx_full) is sampled in this same cycle.
  - If `rd[2]`=1, return to `S_IDLE` with no ready pulse. The pointer has already advanced, so other requesters are not starved.
  - If `rd[2]`=0, go to `S_WR`.
- `S_WR`: `we`=1, `addr`=`ADDR_TX_RX`, `wd`={24'h0,held byte}.
  - The granted `txN_ready` is 1 in this cycle.
  - Next state `S_IDLE`.
- `S_RX`: `re`=1, `addr`=`ADDR_TX_RX`.
  - `rd[7:0]` is registered into `rx_data` at the end of the cycle.
  - `rx_valid` is 1 in the following cycle.
  - Next state `S_IDLE`.
- In `S_IDLE`, `S_DIV` and `S_CR`, `addr` is 0 unless stated above. `wd` is 0 whenever `we`=0.
- Requesters must hold `valid` and data until `ready`. If `valid` drops after grant, the latched byte is still sent and `ready` still pulses.
- The block does not check RX FIFO emptiness. Clients raise `rx_req` only when data is known present (e.g. on UART irq).

## Timing
- Reset values: `addr`=0, `re`=0, `we`=0, `wd`=0, `tx0_ready`=`tx1_ready`=0, `rx_valid`=0, `rx_data`=0, `init_done`=0.
- Reset assertion is asynchronous. It aborts any transaction mid-flight and restarts at `S_DIV`.
- After reset release, bus activity is:
  - cycle 1: `S_DIV` write
  - cycle 2: `S_CR` write
  - cycle 3: `init_done`=1
- TX latency: if `txN_valid` is sampled in `S_IDLE` at edge k, then `S_POLL` is cycle k+1 and `S_WR` with `ready` is cycle k+2.
  - Best-case throughput is 1 byte per 3 cycles.
- RX latency: if `rx_req` is sampled at edge k, then `S_RX` is cycle k+1 and `rx_valid` is cycle k+2.
- `reinit` is only sampled in `S_IDLE`. `init_done` drops in the cycle `S_DIV` is entered.
- Bus outputs depend only on FSM state and internal registers, never combinationally on requester inputs.

## Test plan
- Reset, then release with `div_in`=16'd108, `cr_in`=8'h03 -> DR write of 32'h6C, then CR write of 32'h03, then `init_done`=1 on cycle 3.
- tx0 sends 8'hA5 with tx_full=0 -> CR read, then TX write with `wd`=32'hA5, and `tx0_ready` pulses exactly once at k+2.
- tx0 and tx1 held valid continuously (8'h11/8'h22) -> writes alternate 11, 22, 11, 22, with tx0 first after reset.
- Model holds tx_full=1 for 4 polls while tx1 and rx_req are pending -> no TX write, rx still served with `rx_data` = model byte 8'h3C and `rx_valid` one pulse; the TX byte is written after tx_full clears.
- Assert `rst` during `S_POLL` -> all outputs zero immediately; after release the init sequence repeats and no stale `ready` pulse appears.
- Pulse `reinit` in `S_IDLE` with `div_in`=16'd5 -> DR write 32'h5, then CR write, with `init_done` low for exactly 2 cycles.
